// File: rtl/inst_mem_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared constants, state encoding and address helper for the
//               synchronous instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Bubble instruction: add x0, x0, x0
  localparam logic [31:0] NOP_INST = 32'h0000_0033;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // Widest byte address the helper accepts; callers zero-extend into it
  localparam int ADDR_MAX = 64;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    LOAD = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_MAX-1:0] word;
    logic                in_range;
  } word_info_t;

  // Byte address -> word index, plus whether that word exists in the array.
  // No wrap-around: any index at or beyond depth is reported out of range.
  function automatic word_info_t addr_to_word(input logic [ADDR_MAX-1:0] addr,
                                              input int unsigned         depth);
    word_info_t info;
    info.word     = addr >> 2;
    info.in_range = (info.word < ADDR_MAX'(depth));
    return info;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mem_sync_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_sync_if
// Description : Fetch request/response bus between the core front end
//               (master) and the instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_mem_sync_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              stall;
  logic              flush;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_inst;
  logic [ADDR_W-1:0] rsp_pc;
  logic              rsp_fault;
  logic [1:0]        rsp_fault_code;

  modport master (
    output req_valid, req_addr, stall, flush,
    input  req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault, rsp_fault_code
  );

  modport slave (
    input  req_valid, req_addr, stall, flush,
    output req_ready, rsp_valid, rsp_inst, rsp_pc, rsp_fault, rsp_fault_code
  );
endinterface
`default_nettype wire

// File: rtl/inst_mem_sync_array.sv
`default_nettype none
// ============================================================================
// Module      : imem_array
// Description : Single-port synchronous RAM, DEPTH x XLEN. One read or one
//               write per cycle; read data is registered and holds between
//               reads so a stalled response stays stable.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_array
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 64,
  parameter logic [XLEN-1:0] INIT_WORD = 32'h0000_0033
) (
  input  wire logic                     clk,
  input  wire logic                     i_en,
  input  wire logic                     i_we,
  input  wire logic [$clog2(DEPTH)-1:0] i_addr,
  input  wire logic [XLEN-1:0]          i_wdata,
  output logic      [XLEN-1:0]          o_rdata
);

  // Contents start as bubbles; reset never touches them
  logic [XLEN-1:0] r_mem [DEPTH] = '{default: INIT_WORD};
  logic [XLEN-1:0] r_rdata;

  // Single port: a write suppresses the read and leaves r_rdata untouched
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/inst_mem_sync.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_sync
// Description : Synchronous-read instruction memory with valid/ready fetch,
//               stall/flush, fault reporting and a program-load mode.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_sync
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 64,
  parameter int              ADDR_W   = 32,
  parameter logic [XLEN-1:0] NOP_INST = riscv_pkg::NOP_INST,
  localparam int             IDX_W    = $clog2(DEPTH),
  localparam int             LCW      = $clog2(DEPTH + 1)
) (
  input  wire logic              clk,
  input  wire logic              rst,
  inst_mem_sync_if.slave         bus,
  input  wire logic              i_load_en,
  input  wire logic              i_prog_we,
  input  wire logic [ADDR_W-1:0] i_prog_addr,
  input  wire logic [XLEN-1:0]   i_prog_data,
  output logic                   o_prog_err,
  output logic      [LCW-1:0]    o_load_count
);

  state_t          r_state;
  logic            r_rsp_valid;
  logic            r_rsp_from_mem;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic            r_rsp_fault;
  logic [1:0]      r_rsp_code;
  logic            r_prog_err;
  logic [LCW-1:0]  r_load_count;

  word_info_t      w_req_info;
  word_info_t      w_prog_info;
  logic            w_req_mis;
  logic            w_prog_mis;
  logic            w_fire;
  logic            w_fetch_rd;
  logic            w_prog_ok;
  logic            w_prog_bad;
  logic [XLEN-1:0] w_rdata;

  assign w_req_info  = addr_to_word(ADDR_MAX'(bus.req_addr), DEPTH);
  assign w_prog_info = addr_to_word(ADDR_MAX'(i_prog_addr), DEPTH);
  assign w_req_mis   = |bus.req_addr[1:0];
  assign w_prog_mis  = |i_prog_addr[1:0];

  assign bus.req_ready = (r_state == RUN) & ~bus.stall & ~bus.flush & ~i_load_en;
  assign w_fire        = bus.req_valid & bus.req_ready;
  // Faulting fetches never touch the array
  assign w_fetch_rd    = w_fire & ~w_req_mis & w_req_info.in_range;
  // A write coinciding with reset is dropped
  assign w_prog_ok     = (r_state == LOAD) & i_prog_we & ~w_prog_mis & w_prog_info.in_range & ~rst;
  assign w_prog_bad    = (r_state == LOAD) & i_prog_we & (w_prog_mis | ~w_prog_info.in_range);

  imem_array #(
    .XLEN      (XLEN),
    .DEPTH     (DEPTH),
    .INIT_WORD (NOP_INST)
  ) u_array (
    .clk     (clk),
    .i_en    (w_fetch_rd | w_prog_ok),
    .i_we    (w_prog_ok),
    .i_addr  (w_prog_ok ? IDX_W'(w_prog_info.word) : IDX_W'(w_req_info.word)),
    .i_wdata (i_prog_data),
    .o_rdata (w_rdata)
  );

  // Mode FSM, load counter, error pulse and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_rsp_valid    <= 1'b0;
      r_rsp_from_mem <= 1'b0;
      r_rsp_pc       <= '0;
      r_rsp_fault    <= 1'b0;
      r_rsp_code     <= FAULT_NONE;
      r_prog_err     <= 1'b0;
      r_load_count   <= '0;
    end else begin
      r_prog_err <= w_prog_bad;

      case (r_state)
        RUN: begin
          // Leave only when no response would be lost by the switch
          if (i_load_en && (!r_rsp_valid || !bus.stall)) begin
            r_state      <= LOAD;
            r_load_count <= '0;
          end
        end
        LOAD: begin
          if (!i_load_en) begin
            r_state <= RUN;
          end
          if (w_prog_ok && (r_load_count != LCW'(DEPTH))) begin
            r_load_count <= r_load_count + LCW'(1);
          end
        end
        default: r_state <= RUN;
      endcase

      // flush beats stall; stall freezes everything; otherwise load or bubble
      if (bus.flush) begin
        r_rsp_valid    <= 1'b0;
        r_rsp_from_mem <= 1'b0;
        r_rsp_fault    <= 1'b0;
        r_rsp_code     <= FAULT_NONE;
      end else if (!bus.stall) begin
        if (w_fire) begin
          r_rsp_valid    <= 1'b1;
          r_rsp_pc       <= bus.req_addr;
          r_rsp_from_mem <= ~w_req_mis & w_req_info.in_range;
          r_rsp_fault    <= w_req_mis | ~w_req_info.in_range;
          r_rsp_code     <= w_req_mis               ? FAULT_MISALIGN :
                            !w_req_info.in_range    ? FAULT_RANGE    : FAULT_NONE;
        end else begin
          r_rsp_valid    <= 1'b0;
          r_rsp_from_mem <= 1'b0;
          r_rsp_fault    <= 1'b0;
          r_rsp_code     <= FAULT_NONE;
        end
      end
    end
  end

  assign bus.rsp_valid      = r_rsp_valid;
  assign bus.rsp_inst       = r_rsp_from_mem ? w_rdata : NOP_INST;
  assign bus.rsp_pc         = r_rsp_pc;
  assign bus.rsp_fault      = r_rsp_fault;
  assign bus.rsp_fault_code = r_rsp_code;
  assign o_prog_err         = r_prog_err;
  assign o_load_count       = r_load_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mem_sync
// Description : Scoreboard bench for inst_mem_sync: directed program/fetch
//               sequences followed by randomized traffic against a
//               word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mem_sync;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en, prog_we, prog_err;
  logic [31:0] prog_addr, prog_data;
  logic [6:0]  load_count;

  always #5 clk = ~clk;

  inst_mem_sync_if #(.XLEN(32), .ADDR_W(32)) bus ();

  inst_mem_sync #(
    .XLEN(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_INST(NOP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .i_load_en    (load_en),
    .i_prog_we    (prog_we),
    .i_prog_addr  (prog_addr),
    .i_prog_data  (prog_data),
    .o_prog_err   (prog_err),
    .o_load_count (load_count)
  );

  typedef struct {
    int          cyc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  bit   have_last = 0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  logic [31:0] mmem [DEPTH];
  bit          m_load, m_rsp_valid, m_err, m_known;
  int          m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock of stimulus plus the model's view of what that edge does
  task automatic step(input bit r, input bit rv, input logic [31:0] ra,
                      input bit st, input bit fl, input bit le,
                      input bit pw, input logic [31:0] pa, input logic [31:0] pd);
    bit   rdy, fire, prev_valid;
    exp_t e;
    @(negedge clk);
    rst = r; bus.req_valid = rv; bus.req_addr = ra; bus.stall = st; bus.flush = fl;
    load_en = le; prog_we = pw; prog_addr = pa; prog_data = pd;
    rdy = m_known && !m_load && !st && !fl && !le;
    #1;
    if (m_known) chk("req_ready", 32'(bus.req_ready), 32'(rdy));
    fire       = rv && rdy;
    prev_valid = m_rsp_valid;
    if (r) begin
      m_load = 0; m_rsp_valid = 0; m_cnt = 0; m_err = 0; m_known = 1;
    end else if (m_known) begin
      m_err = 0;
      if (m_load && pw) begin
        if (pa[1:0] == 2'b00 && (pa >> 2) < 32'(DEPTH)) begin
          mmem[pa[7:2]] = pd;
          if (m_cnt < DEPTH) m_cnt++;
        end else begin
          m_err = 1;
        end
      end
      if (fl) begin
        m_rsp_valid = 0;
      end else if (!st) begin
        if (fire) begin
          e.cyc = cyc + 1;
          e.pc  = ra;
          if (ra[1:0] != 2'b00) begin
            e.inst = NOP; e.fault = 1; e.code = 2'b01;
          end else if ((ra >> 2) >= 32'(DEPTH)) begin
            e.inst = NOP; e.fault = 1; e.code = 2'b10;
          end else begin
            e.inst = mmem[ra[7:2]]; e.fault = 0; e.code = 2'b00;
          end
          exp_q.push_back(e);
          m_rsp_valid = 1;
        end else begin
          m_rsp_valid = 0;
        end
      end
      if (!m_load) begin
        if (le && (!prev_valid || !st)) begin m_load = 1; m_cnt = 0; end
      end else if (!le) begin
        m_load = 0;
      end
    end
    @(posedge clk);
    #1;
    if (m_known) begin
      chk("prog_err",   32'(prog_err),      32'(m_err));
      chk("load_count", 32'(load_count),    32'(m_cnt));
      chk("rsp_valid",  32'(bus.rsp_valid), 32'(m_rsp_valid));
      if (!m_rsp_valid) begin
        chk("idle_inst",  bus.rsp_inst,       NOP);
        chk("idle_fault", 32'(bus.rsp_fault), 32'd0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a);
    step(0, 1, a, 0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic prog(input bit r, input logic [31:0] a, input logic [31:0] d);
    step(r, 0, 32'h0, 0, 0, 1, 1, a, d);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned k;
    k = $urandom % 10;
    if (k == 0) return 32'(($urandom % DEPTH) * 4 + 1 + ($urandom % 3));
    if (k == 1) return ($urandom | 32'h100) & 32'hFFFF_FFFC;
    return 32'(($urandom % DEPTH) * 4);
  endfunction

  // Monitor: new response -> pop and compare; stalled response -> must hold
  bit mon_st, mon_fl, mon_rst;
  always @(posedge clk) begin
    exp_t e;
    mon_st = bus.stall; mon_fl = bus.flush; mon_rst = rst;
    #1;
    if (bus.rsp_valid === 1'b1) begin
      checks++;
      if (mon_st && !mon_fl && !mon_rst && have_last) begin
        if (bus.rsp_pc !== last.pc || bus.rsp_inst !== last.inst ||
            bus.rsp_fault !== last.fault || bus.rsp_fault_code !== last.code) begin
          failures++;
          $display("FAIL rsp_hold actual pc=%h inst=%h fault=%b code=%b required pc=%h inst=%h fault=%b code=%b",
                   bus.rsp_pc, bus.rsp_inst, bus.rsp_fault, bus.rsp_fault_code,
                   last.pc, last.inst, last.fault, last.code);
        end
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected actual pc=%h inst=%h at cycle %0d required no response",
                 bus.rsp_pc, bus.rsp_inst, cyc);
      end else begin
        e = exp_q.pop_front();
        last = e; have_last = 1;
        if (cyc != e.cyc || bus.rsp_pc !== e.pc || bus.rsp_inst !== e.inst ||
            bus.rsp_fault !== e.fault || bus.rsp_fault_code !== e.code) begin
          failures++;
          $display("FAIL rsp_data actual cyc=%0d pc=%h inst=%h fault=%b code=%b required cyc=%0d pc=%h inst=%h fault=%b code=%b",
                   cyc, bus.rsp_pc, bus.rsp_inst, bus.rsp_fault, bus.rsp_fault_code,
                   e.cyc, e.pc, e.inst, e.fault, e.code);
        end
      end
    end
  end

  initial begin
    bit          r, rv, st, fl, pw;
    bit          le_r;
    logic [31:0] ra, pa, pd;

    for (int i = 0; i < DEPTH; i++) mmem[i] = NOP;
    m_load = 0; m_rsp_valid = 0; m_err = 0; m_known = 0; m_cnt = 0;
    rst = 1; bus.req_valid = 0; bus.req_addr = 0; bus.stall = 0; bus.flush = 0;
    load_en = 0; prog_we = 0; prog_addr = 0; prog_data = 0;

    // Reset state
    step(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0);
    chk("reset_valid", 32'(bus.rsp_valid),      32'd0);
    chk("reset_inst",  bus.rsp_inst,            NOP);
    chk("reset_pc",    bus.rsp_pc,              32'd0);
    chk("reset_code",  32'(bus.rsp_fault_code), 32'd0);

    // Program two words, return to RUN
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    prog(0, 32'h0, 32'h0000_2083);
    prog(0, 32'h4, 32'h0040_2103);
    idle(1);
    chk("load_count_two", 32'(load_count), 32'd2);

    // Back-to-back fetches including an unwritten word
    fetch(32'h0); fetch(32'h4); fetch(32'h8);
    idle(1);

    // Stall freezes the response for three cycles
    fetch(32'h4);
    for (int i = 0; i < 3; i++) step(0, 1, 32'h8, 1, 0, 0, 0, 32'h0, 32'h0);
    chk("stall_pc",   bus.rsp_pc,   32'h4);
    chk("stall_inst", bus.rsp_inst, 32'h0040_2103);
    fetch(32'h8);
    idle(1);

    // Misaligned and out-of-range faults
    fetch(32'h6); fetch(32'h100); fetch(32'hFC);
    idle(1);

    // Flush kills the in-flight response; flush beats stall
    fetch(32'h4);
    step(0, 1, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0);
    fetch(32'h4);
    step(0, 1, 32'h8, 1, 1, 0, 0, 32'h0, 32'h0);
    idle(1);

    // Bad program write, good write, reset during LOAD drops its write
    step(0, 0, 32'h0, 0, 0, 1, 0, 32'h0, 32'h0);
    prog(0, 32'h102, 32'hDEAD_BEEF);
    prog(0, 32'h8,   32'h1111_1111);
    prog(1, 32'hC,   32'h2222_2222);
    idle(1);
    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle(2);

    // Randomized traffic
    le_r = 0;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom % 80) == 0;
      if (($urandom % 12) == 0) le_r = !le_r;
      st = ($urandom % 6) == 0;
      fl = ($urandom % 10) == 0;
      rv = ($urandom % 4) != 0;
      pw = ($urandom % 2) == 0;
      ra = rand_addr();
      pa = rand_addr();
      pd = $urandom;
      step(r, rv, ra, st, fl, le_r, pw, pa, pd);
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_mem_sync.md
Name: inst_mem_sync

Overview:
- Parametrised, synchronous-read instruction memory for the pipelined RISC-V core. Replaces the fixed 64x32 combinational ROM.
- Accepts byte-addressed fetch requests through a valid/ready handshake and returns the instruction one cycle later.
- Supports pipeline stall and flush, reports misaligned and out-of-range fetches as faults, and has a program-load mode so the bench or boot logic can write the program instead of using hard-coded contents.

Parameters:
- XLEN, 32, instruction/data width in bits.
- DEPTH, 64, number of instruction words (power of two, >= 2).
- ADDR_W, 32, width of the fetch and program byte addresses.
- NOP_INST, 32'h0000_0033, bubble instruction (add x0,x0,x0).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  fetch request.
- req_ready  out  1  request accepted this cycle.
- req_addr  in  ADDR_W  fetch byte address (PC).
- stall  in  1  hold the current response; accept no request.
- flush  in  1  kill the in-flight response.
- rsp_valid  out  1  rsp_* fields are valid.
- rsp_inst  out  XLEN  fetched instruction.
- rsp_pc  out  ADDR_W  byte address of rsp_inst.
- rsp_fault  out  1  fetch fault.
- rsp_fault_code  out  2  01 = misaligned, 10 = out of range, 00 = none.
- load_en  in  1  request program-load mode.
- prog_we  in  1  program write strobe (honoured only in LOAD).
- prog_addr  in  ADDR_W  program write byte address.
- prog_data  in  XLEN  program write data.
- prog_err  out  1  one-cycle pulse on a bad program write.
- load_count  out  $clog2(DEPTH+1)  words written since entering LOAD, saturating.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: rsp_valid=0, rsp_inst=NOP_INST, rsp_pc=0, rsp_fault=0, rsp_fault_code=00, prog_err=0, load_count=0.
  - State goes to RUN.
  - Array contents are not changed by reset. The array is initialised to NOP_INST at time zero.
- States:
  - RUN: RUN -> LOAD when load_en=1 and no response is pending (rsp_valid=0, or stall=0).
  - LOAD: LOAD -> RUN on the first cycle with load_en=0. load_count is cleared on entry to LOAD.
- Handshake: req_ready = (state==RUN) & !stall & !flush & !load_en. A transfer occurs when req_valid & req_ready.
- Latency: on a transfer in cycle N, in cycle N+1 the block drives rsp_valid=1, rsp_pc=req_addr and rsp_inst=mem[req_addr[$clog2(DEPTH)+1:2]].
- Fault checks (priority order):
  1. req_addr[1:0]!=0 gives code 01.
  2. Otherwise req_addr>>2 >= DEPTH gives code 10.
  - On a fault: rsp_valid=1, rsp_fault=1, rsp_inst=NOP_INST. The memory is not read.
- No transfer, no stall, no flush: rsp_valid=0 next cycle, rsp_inst=NOP_INST, rsp_fault=0.
- stall=1 (without flush): all rsp_* outputs hold their values. Back-to-back transfers resume on the cycle after stall falls.
- flush=1: next cycle rsp_valid=0, rsp_inst=NOP_INST, rsp_fault=0. flush beats stall. A request presented with flush is not accepted.
- LOAD mode:
  - req_ready=0 and rsp_valid=0.
  - prog_we writes prog_data to word prog_addr>>2 at the clock edge and increments load_count.
  - Misaligned or out-of-range prog_addr: no write, prog_err=1 for one cycle, load_count unchanged.
  - prog_we in RUN is ignored (no write, no error).
- Read-after-write: the first fetch after returning to RUN sees all writes made in LOAD.
- Reset during LOAD: returns to RUN. Words already written are kept. A write in the same cycle as reset is dropped.
- Fetch address wrap-around is not allowed: an out-of-range address always faults.

Decomposition:
- Package riscv_pkg:
  - NOP_INST constant.
  - Fault-code constants FAULT_NONE/FAULT_MISALIGN/FAULT_RANGE.
  - State enum {RUN, LOAD}.
  - Function addr_to_word(addr, DEPTH) returning the word index and a range flag.
- Sub-module: imem_array, a single-port synchronous RAM (DEPTH x XLEN, one read or one write per cycle).
  - The mode decides which port is active.
  - inst_mem_sync holds the FSM, handshake, fault logic and response registers.

Test Plan:
- Reset, then LOAD: write 0x0000_2083 at 0x0, 0x0040_2103 at 0x4, then load_en=0 -> load_count=2. Fetches of 0x0 and 0x4 return those words one cycle later with matching rsp_pc.
- Back-to-back fetches 0x0, 0x4, 0x8 with req_valid held high -> three consecutive rsp_valid cycles in order. The unwritten word 0x8 returns 0x0000_0033.
- Fetch 0x4, then stall=1 for 3 cycles -> rsp_inst/rsp_pc frozen at 0x0040_2103/0x4 and req_ready=0. Fetch resumes on the cycle after stall falls.
- Fetch 0x6 -> rsp_fault=1, code 01, rsp_inst=NOP. Fetch 0x100 with DEPTH=64 -> code 10.
- Fetch 0x4 with flush=1 in the response cycle -> next cycle rsp_valid=0. flush together with stall and req_valid -> req_ready=0 and the response is killed.
- In LOAD, prog_addr=0x102 -> prog_err pulse, no write. Assert rst during LOAD -> state RUN, rsp_valid=0, and earlier program words are still readable.
